// File: rtl/decode_stage_pkg.sv
// package_param: opcodes, instruction class enum and opcode-to-class helper for decode_stage
// Contents:
//   RTYPE..U2TYPE : 7-bit RV32 major opcodes
//   cls_e         : 4-bit instruction class code presented on o_class
//   op_class()    : maps opcode[6:0] to cls_e, unknown opcodes give CLS_ILLEGAL
package package_param;
   localparam logic [6:0] RTYPE  = 7'b0110011;
   localparam logic [6:0] ITYPE  = 7'b0010011;
   localparam logic [6:0] ILTYPE = 7'b0000011;
   localparam logic [6:0] IITYPE = 7'b1100111;
   localparam logic [6:0] IJTYPE = 7'b1101111;
   localparam logic [6:0] STYPE  = 7'b0100011;
   localparam logic [6:0] BTYPE  = 7'b1100011;
   localparam logic [6:0] U1TYPE = 7'b0110111;
   localparam logic [6:0] U2TYPE = 7'b0010111;
   localparam int CLS_W = 4;
   typedef enum logic [CLS_W-1:0] {
      CLS_R, CLS_I_ALU, CLS_I_LOAD, CLS_JALR, CLS_JAL,
      CLS_S, CLS_B, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
   } cls_e;
   function automatic cls_e op_class(input logic [6:0] op);
      return op == RTYPE  ? CLS_R      :
             op == ITYPE  ? CLS_I_ALU  :
             op == ILTYPE ? CLS_I_LOAD :
             op == IITYPE ? CLS_JALR   :
             op == IJTYPE ? CLS_JAL    :
             op == STYPE  ? CLS_S      :
             op == BTYPE  ? CLS_B      :
             op == U1TYPE ? CLS_LUI    :
             op == U2TYPE ? CLS_AUIPC  : CLS_ILLEGAL;
   endfunction
endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate extraction, sign-extended to XLEN
// Ports:
//   inst_i : instruction word
//   cls_i  : instruction class (package_param::cls_e code)
//   imm_o  : immediate, zero for R-type and illegal instructions
module imm_gen
   import package_param::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]      inst_i,
   input  logic [CLS_W-1:0] cls_i,
   output logic [XLEN-1:0]  imm_o
);
   logic [31:0] imm32;
   always_comb begin
      imm32 = (cls_i == CLS_I_ALU || cls_i == CLS_I_LOAD || cls_i == CLS_JALR) ?
                 {{20{inst_i[31]}}, inst_i[31:20]} :
              cls_i == CLS_S ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
              cls_i == CLS_B ? {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
              cls_i == CLS_JAL ? {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
              (cls_i == CLS_LUI || cls_i == CLS_AUIPC) ? {inst_i[31:12], 12'b0} : 32'b0;
   end
   // imm32 already carries inst[31] in its MSB, so a signed resize finishes the extension
   assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-entry registered RV32 decode stage with valid/ready handshakes
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_valid/o_ready       : upstream handshake carrying i_inst, i_pc
//   i_flush               : drop the held and the incoming instruction
//   o_valid/i_ready       : downstream handshake
//   o_pc, o_class, o_rd, o_rs1, o_rs2, o_funct3, o_funct7b5, o_imm, o_illegal : decoded fields
//   o_inst_cnt            : accepted legal instruction count, only with DECODE_PERF_CNT_EN defined
module decode_stage
   import package_param::*;
#(
   parameter int XLEN = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_inst,
   input  logic [XLEN-1:0]  i_pc,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_pc,
   output logic [3:0]       o_class,
   output logic [4:0]       o_rd,
   output logic [4:0]       o_rs1,
   output logic [4:0]       o_rs2,
   output logic [2:0]       o_funct3,
   output logic             o_funct7b5,
   output logic [XLEN-1:0]  o_imm,
`ifdef DECODE_PERF_CNT_EN
   output logic [31:0]      o_inst_cnt,
`endif
   output logic             o_illegal
);
   logic            valid_q, valid_d, ill_q, f7b5_q, load;
   logic [XLEN-1:0] pc_q, imm_q, imm_d;
   cls_e            cls_q, cls_d;
   logic [4:0]      rd_q, rs1_q, rs2_q;
   logic [2:0]      f3_q;
   assign o_ready = !valid_q || i_ready;
   // flush wins over a simultaneous accept, so nothing is loaded in that cycle
   assign load    = i_valid && o_ready && !i_flush;
   assign valid_d = i_flush ? 1'b0 : o_ready ? i_valid : valid_q;
   assign cls_d   = op_class(i_inst[6:0]);
   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst_i (i_inst),
      .cls_i  (cls_d),
      .imm_o  (imm_d)
   );
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         cls_q   <= CLS_ILLEGAL;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         f3_q    <= '0;
         f7b5_q  <= 1'b0;
         imm_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (load) begin
            pc_q   <= i_pc;
            cls_q  <= cls_d;
            rd_q   <= i_inst[11:7];
            rs1_q  <= i_inst[19:15];
            rs2_q  <= i_inst[24:20];
            f3_q   <= i_inst[14:12];
            f7b5_q <= i_inst[30];
            imm_q  <= imm_d;
            ill_q  <= cls_d == CLS_ILLEGAL;
         end
      end
   end
   assign o_valid    = valid_q;
   assign o_pc       = pc_q;
   assign o_class    = cls_q;
   assign o_rd       = rd_q;
   assign o_rs1      = rs1_q;
   assign o_rs2      = rs2_q;
   assign o_funct3   = f3_q;
   assign o_funct7b5 = f7b5_q;
   assign o_imm      = imm_q;
   assign o_illegal  = ill_q;
`ifdef DECODE_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;
   assign cnt_d = (load && cls_d != CLS_ILLEGAL) ? cnt_q + 32'd1 : cnt_q;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign o_inst_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven, directed and randomized checks of decode_stage against a reference model
module tb_decode_stage;
   import package_param::*;
   localparam int XLEN = 32;
   logic i_clk, i_rst, i_valid, o_ready, i_flush, o_valid, i_ready, o_funct7b5, o_illegal;
   logic [31:0] i_inst, i_pc, o_pc, o_imm;
   logic [3:0] o_class;
   logic [4:0] o_rd, o_rs1, o_rs2;
   logic [2:0] o_funct3;
`ifdef DECODE_PERF_CNT_EN
   logic [31:0] o_inst_cnt;
`endif
   decode_stage #(.XLEN(XLEN)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
      .i_ready(i_ready), .o_pc(o_pc), .o_class(o_class), .o_rd(o_rd),
      .o_rs1(o_rs1), .o_rs2(o_rs2), .o_funct3(o_funct3), .o_funct7b5(o_funct7b5),
      .o_imm(o_imm),
`ifdef DECODE_PERF_CNT_EN
      .o_inst_cnt(o_inst_cnt),
`endif
      .o_illegal(o_illegal)
   );
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;
   typedef struct {
      logic [31:0] pc;
      logic [3:0]  cls;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic        f7b5;
      logic [31:0] imm;
      logic        ill;
   } exp_t;
   typedef struct {
      logic [31:0] inst, pc;
      logic [3:0]  cls;
      logic [4:0]  rd, rs1;
      logic [31:0] imm;
      logic        ill;
   } vec_t;
   int checks = 0, errors = 0;
   logic m_valid;
   exp_t m_exp;
   logic [31:0] m_cnt;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask
   function automatic exp_t reset_exp();
      exp_t e;
      e.pc = 0; e.cls = CLS_ILLEGAL; e.rd = 0; e.rs1 = 0; e.rs2 = 0;
      e.f3 = 0; e.f7b5 = 0; e.imm = 0; e.ill = 0;
      return e;
   endfunction
   // Reference decode: class table by opcode, immediates assembled arithmetically
   function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
      exp_t e;
      int s;
      logic [6:0] op;
      s = $signed(inst);
      op = inst[6:0];
      e.pc = pc; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
      e.f3 = inst[14:12]; e.f7b5 = inst[30];
      case (op)
         7'h33: e.cls = CLS_R;
         7'h13: e.cls = CLS_I_ALU;
         7'h03: e.cls = CLS_I_LOAD;
         7'h67: e.cls = CLS_JALR;
         7'h6F: e.cls = CLS_JAL;
         7'h23: e.cls = CLS_S;
         7'h63: e.cls = CLS_B;
         7'h37: e.cls = CLS_LUI;
         7'h17: e.cls = CLS_AUIPC;
         default: e.cls = CLS_ILLEGAL;
      endcase
      e.ill = e.cls == CLS_ILLEGAL;
      case (e.cls)
         CLS_I_ALU, CLS_I_LOAD, CLS_JALR: e.imm = s >>> 20;
         CLS_S: e.imm = ((s >>> 25) <<< 5) | int'(inst[11:7]);
         CLS_B: e.imm = ((s >>> 31) <<< 12) | (int'(inst[7]) << 11) | (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
         CLS_JAL: e.imm = ((s >>> 31) <<< 20) | (int'(inst[19:12]) << 12) | (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
         CLS_LUI, CLS_AUIPC: e.imm = inst & 32'hFFFFF000;
         default: e.imm = 0;
      endcase
      return e;
   endfunction
   task automatic chk_fields(input string tag);
      chk({tag, ".pc"}, o_pc, m_exp.pc);
      chk({tag, ".class"}, 32'(o_class), 32'(m_exp.cls));
      chk({tag, ".rd"}, 32'(o_rd), 32'(m_exp.rd));
      chk({tag, ".rs1"}, 32'(o_rs1), 32'(m_exp.rs1));
      chk({tag, ".rs2"}, 32'(o_rs2), 32'(m_exp.rs2));
      chk({tag, ".funct3"}, 32'(o_funct3), 32'(m_exp.f3));
      chk({tag, ".funct7b5"}, 32'(o_funct7b5), 32'(m_exp.f7b5));
      chk({tag, ".imm"}, o_imm, m_exp.imm);
      chk({tag, ".illegal"}, 32'(o_illegal), 32'(m_exp.ill));
   endtask
   task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl);
      exp_t n;
      logic room;
      @(negedge i_clk);
      i_valid = v; i_inst = inst; i_pc = pc; i_ready = rdy; i_flush = fl;
      #1;
      room = !m_valid || rdy;
      chk("o_ready", 32'(o_ready), 32'(room));
      n = model(inst, pc);
      if (v && room && !fl) begin
         m_exp = n;
         if (!n.ill) m_cnt = m_cnt + 1;
      end
      m_valid = fl ? 1'b0 : room ? v : m_valid;
      @(posedge i_clk);
      #1;
      chk("o_valid", 32'(o_valid), 32'(m_valid));
      if (m_valid) chk_fields("out");
`ifdef DECODE_PERF_CNT_EN
      chk("o_inst_cnt", o_inst_cnt, m_cnt);
`endif
   endtask
   vec_t tbl[10];
   logic [6:0] ops[9];
   exp_t held;
   initial begin
      tbl[0] = '{32'h00500093, 32'h100, CLS_I_ALU,   5'd1,  5'd0, 32'h00000005, 1'b0};
      tbl[1] = '{32'h12345137, 32'h104, CLS_LUI,     5'd2,  5'd8, 32'h12345000, 1'b0};
      tbl[2] = '{32'hFE000EE3, 32'h108, CLS_B,       5'd29, 5'd0, 32'hFFFFFFFC, 1'b0};
      tbl[3] = '{32'h0000007F, 32'h10C, CLS_ILLEGAL, 5'd0,  5'd0, 32'h00000000, 1'b1};
      tbl[4] = '{32'h008000EF, 32'h110, CLS_JAL,     5'd1,  5'd0, 32'h00000008, 1'b0};
      tbl[5] = '{32'h00001197, 32'h114, CLS_AUIPC,   5'd3,  5'd0, 32'h00001000, 1'b0};
      tbl[6] = '{32'h002081B3, 32'h118, CLS_R,       5'd3,  5'd1, 32'h00000000, 1'b0};
      tbl[7] = '{32'hFFC12283, 32'h11C, CLS_I_LOAD,  5'd5,  5'd2, 32'hFFFFFFFC, 1'b0};
      tbl[8] = '{32'h00008067, 32'h120, CLS_JALR,    5'd0,  5'd1, 32'h00000000, 1'b0};
      tbl[9] = '{32'hFE512C23, 32'h124, CLS_S,       5'd24, 5'd2, 32'hFFFFFFF8, 1'b0};
      ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h6F, 7'h23, 7'h63, 7'h37, 7'h17};
      i_rst = 1'b1; i_valid = 0; i_inst = 0; i_pc = 0; i_flush = 0; i_ready = 0;
      m_valid = 0; m_exp = reset_exp(); m_cnt = 0;
      repeat (2) @(negedge i_clk);
      chk("rst.o_valid", 32'(o_valid), 32'd0);
      chk_fields("rst");
`ifdef DECODE_PERF_CNT_EN
      chk("rst.o_inst_cnt", o_inst_cnt, 32'd0);
`endif
      i_rst = 1'b0;
      step(0, 32'h00500093, 32'h0, 1, 0);
      foreach (tbl[i]) begin
         step(1, tbl[i].inst, tbl[i].pc, 1, 0);
         chk("tbl.valid", 32'(o_valid), 32'd1);
         chk("tbl.class", 32'(o_class), 32'(tbl[i].cls));
         chk("tbl.rd", 32'(o_rd), 32'(tbl[i].rd));
         chk("tbl.rs1", 32'(o_rs1), 32'(tbl[i].rs1));
         chk("tbl.imm", o_imm, tbl[i].imm);
         chk("tbl.illegal", 32'(o_illegal), 32'(tbl[i].ill));
         chk("tbl.pc", o_pc, tbl[i].pc);
      end
      step(1, 32'h00500093, 32'h200, 1, 0);
      held = m_exp;
      for (int k = 0; k < 3; k++) begin
         step(1, 32'h12345137, 32'h204, 0, 0);
         chk("stall.o_ready", 32'(o_ready), 32'd0);
         chk("stall.pc", o_pc, held.pc);
         chk("stall.imm", o_imm, held.imm);
         chk("stall.class", 32'(o_class), 32'(held.cls));
      end
      step(1, 32'h12345137, 32'h204, 1, 0);
      chk("release.class", 32'(o_class), 32'(CLS_LUI));
      chk("release.pc", o_pc, 32'h204);
      step(1, 32'hFE000EE3, 32'h300, 1, 1);
      chk("flush_accept.valid", 32'(o_valid), 32'd0);
      step(1, 32'h00500093, 32'h304, 1, 0);
      step(1, 32'h12345137, 32'h308, 0, 1);
      chk("flush_held.valid", 32'(o_valid), 32'd0);
      step(1, 32'h00500093, 32'h400, 1, 0);
      step(1, 32'h12345137, 32'h404, 0, 0);
      @(negedge i_clk);
      #2 i_rst = 1'b1;
      #1;
      m_valid = 0; m_exp = reset_exp(); m_cnt = 0;
      chk("midrst.o_valid", 32'(o_valid), 32'd0);
      chk("midrst.o_ready", 32'(o_ready), 32'd1);
      chk_fields("midrst");
`ifdef DECODE_PERF_CNT_EN
      chk("midrst.o_inst_cnt", o_inst_cnt, 32'd0);
`endif
      @(negedge i_clk);
      i_valid = 0;
      i_rst = 1'b0;
      step(0, 32'h00500093, 32'h500, 1, 0);
      chk("post_rst.valid", 32'(o_valid), 32'd0);
`ifdef DECODE_PERF_CNT_EN
      step(0, 32'h0, 32'h0, 1, 0);
      force dut.cnt_q = 32'hFFFFFFFF;
      #1 release dut.cnt_q;
      m_cnt = 32'hFFFFFFFF;
      step(1, 32'h00500093, 32'h600, 1, 0);
      chk("cnt_wrap", o_inst_cnt, 32'd0);
`endif
      for (int k = 0; k < 400; k++) begin
         logic [31:0] r;
         int idx;
         r = $urandom();
         idx = $urandom_range(0, 9);
         if (idx < 9) r[6:0] = ops[idx];
         step($urandom_range(0, 3) != 0, r, $urandom(), $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
